// File: rtl/fs_pkg.sv
// Shared definitions for the full-subtractor fault-injection flow:
// bit positions inside a {A,B,Bin} vector, the responder FSM states
// and the golden full-subtractor function.
package fs_pkg;

    // Bit positions of the operands inside a {A,B,Bin} vector
    localparam int unsigned IDX_A   = 2;
    localparam int unsigned IDX_B   = 1;
    localparam int unsigned IDX_BIN = 0;

    // Vector width
    localparam int unsigned VEC_W = 3;

    // Responder output-register occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fs_state_t;

    // Full subtractor A - B - Bin, returned as {d, bout}
    function automatic logic [1:0] fs_eval(
        input logic a,
        input logic b,
        input logic bin
    );
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
        return {d, bout};
    endfunction

endpackage

// File: rtl/fs_sat_counter.sv
// Saturating up-counter. Counts inc pulses and holds at all-ones;
// it is cleared only by reset.
module fs_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Increment on inc unless already at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fs_fault_responder.sv
// Fault-injecting full-subtractor responder. Accepts {A,B,Bin} vectors
// over valid/ready, forces stuck-at faults from runtime-programmable
// masks and returns the faulty {D,Bout} plus a golden-compare flag.
// A one-entry output register gives full throughput: a new vector may
// be accepted in the same cycle the held response is consumed.
module fs_fault_responder
    import fs_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_sa0,
    input  logic [2:0]       cfg_sa1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_d,
    output logic             out_bout,
    output logic             out_mismatch,
    output logic             fault_active,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count
);

    fs_state_t        state;
    logic [VEC_W-1:0] sa0_q;
    logic [VEC_W-1:0] sa1_q;
    logic [VEC_W-1:0] eff;
    logic [1:0]       golden;
    logic [1:0]       faulty;
    logic             mismatch;
    logic             accept;

    // Fault masks; a vector accepted in the same cycle still sees the old masks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa0_q <= '0;
            sa1_q <= '0;
        end else if (cfg_we) begin
            sa0_q <= cfg_sa0;
            sa1_q <= cfg_sa1;
        end
    end

    assign fault_active = |(sa0_q | sa1_q);

    // Apply masks (stuck-at-0 wins) and evaluate golden and faulty responses
    always_comb begin
        eff      = (in_vec & ~sa0_q) | (sa1_q & ~sa0_q);
        golden   = fs_eval(in_vec[IDX_A], in_vec[IDX_B], in_vec[IDX_BIN]);
        faulty   = fs_eval(eff[IDX_A], eff[IDX_B], eff[IDX_BIN]);
        mismatch = (golden != faulty);
    end

    assign in_ready = (state == EMPTY) | out_ready;
    assign accept   = in_valid & in_ready;

    // Output-register FSM; response fields only load on accept so they hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            out_valid    <= 1'b0;
            out_d        <= 1'b0;
            out_bout     <= 1'b0;
            out_mismatch <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state        <= FULL;
                        out_valid    <= 1'b1;
                        out_d        <= faulty[1];
                        out_bout     <= faulty[0];
                        out_mismatch <= mismatch;
                    end
                end
                FULL: begin
                    if (accept) begin
                        out_d        <= faulty[1];
                        out_bout     <= faulty[0];
                        out_mismatch <= mismatch;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    fs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_vec_count (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (accept),
        .count(vec_count)
    );

    fs_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_count (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (accept & mismatch),
        .count(err_count)
    );

endmodule

// File: tb/tb_fs_fault_responder.sv
// Bench for fs_fault_responder: directed vector table, hand-written
// stall / config-collision / saturation / reset sequences, and a random
// run checked against a behavioural model.
module tb_fs_fault_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_sa0, cfg_sa1;
    logic       in_valid, in_ready;
    logic [2:0] in_vec;
    logic       out_valid, out_ready, out_d, out_bout, out_mismatch, fault_active;
    logic [7:0] vec_count, err_count;

    logic       rst_n2;
    logic       cfg_we2;
    logic [2:0] cfg_sa0_2, cfg_sa1_2;
    logic       in_valid2, in_ready2;
    logic [2:0] in_vec2;
    logic       out_valid2, out_ready2, out_d2, out_bout2, out_mismatch2, fault_active2;
    logic [1:0] vec_count2, err_count2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fs_fault_responder #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sa0(cfg_sa0), .cfg_sa1(cfg_sa1),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_bout(out_bout),
        .out_mismatch(out_mismatch), .fault_active(fault_active),
        .vec_count(vec_count), .err_count(err_count)
    );

    fs_fault_responder #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n2), .cfg_we(cfg_we2), .cfg_sa0(cfg_sa0_2), .cfg_sa1(cfg_sa1_2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_vec(in_vec2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_d(out_d2), .out_bout(out_bout2),
        .out_mismatch(out_mismatch2), .fault_active(fault_active2),
        .vec_count(vec_count2), .err_count(err_count2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: A - B - Bin as an integer; D is its low bit, Bout its sign
    function automatic logic [1:0] ref_eval(input logic [2:0] v);
        int diff;
        logic d, bo;
        diff = int'(v[2]) - int'(v[1]) - int'(v[0]);
        d    = (diff % 2) != 0;
        bo   = diff < 0;
        return {d, bo};
    endfunction

    function automatic logic [2:0] ref_eff(input logic [2:0] v, input logic [2:0] s0,
                                           input logic [2:0] s1);
        logic [2:0] r;
        for (int unsigned i = 0; i < 3; i++) begin
            if (s0[i])      r[i] = 1'b0;
            else if (s1[i]) r[i] = 1'b1;
            else            r[i] = v[i];
        end
        return r;
    endfunction

    typedef struct {
        logic [2:0] sa0;
        logic [2:0] sa1;
        logic [2:0] vec;
        logic       d;
        logic       bout;
        logic       mm;
    } vec_rec_t;

    vec_rec_t tbl[12];

    // Configure masks in one cycle, then accept one vector
    task automatic apply(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] v,
                         input logic rdy);
        cfg_we = 1'b1; cfg_sa0 = s0; cfg_sa1 = s1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b1; in_vec = v; out_ready = rdy;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Model state for the random phase
    logic [2:0] m_sa0, m_sa1;
    int         m_vcnt, m_ecnt;
    logic       held_v, held_d, held_b, held_m;

    initial begin
        logic [1:0] f, g;
        logic       m_rdy, acc;

        tbl[0]  = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{3'b000, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{3'b000, 3'b000, 3'b010, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{3'b000, 3'b000, 3'b011, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{3'b000, 3'b000, 3'b100, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{3'b000, 3'b000, 3'b101, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{3'b000, 3'b000, 3'b110, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{3'b000, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0};
        // A stuck at 0: 111 evaluates as 011 -> D=0, Bout=1
        tbl[8]  = '{3'b100, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'b011, 3'b000, 3'b111, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{3'b100, 3'b100, 3'b011, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_sa0 = '0; cfg_sa1 = '0;
        in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        rst_n2 = 1'b0; cfg_we2 = 1'b0; cfg_sa0_2 = '0; cfg_sa1_2 = '0;
        in_valid2 = 1'b0; in_vec2 = '0; out_ready2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n2 = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_d", out_d, 1'b0);
        check("rst_out_bout", out_bout, 1'b0);
        check("rst_out_mismatch", out_mismatch, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fault_active", fault_active, 1'b0);
        check("rst_vec_count", vec_count, 8'd0);
        check("rst_err_count", err_count, 8'd0);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].sa0, tbl[i].sa1, tbl[i].vec, 1'b1);
            check($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
            check($sformatf("tbl%0d_d", i), out_d, tbl[i].d);
            check($sformatf("tbl%0d_bout", i), out_bout, tbl[i].bout);
            check($sformatf("tbl%0d_mm", i), out_mismatch, tbl[i].mm);
            if (i == 7) begin
                check("clean_vec_count", vec_count, 8'd8);
                check("clean_err_count", err_count, 8'd0);
            end
        end
        check("tbl_vec_count", vec_count, 8'd12);
        check("tbl_err_count", err_count, 8'd2);

        // Backpressure: held response survives stall and a mid-stall mask write
        apply(3'b000, 3'b000, 3'b101, 1'b0);
        in_valid = 1'b1; in_vec = 3'b000;
        for (int k = 0; k < 5; k++) begin
            cfg_we = (k == 2); cfg_sa0 = 3'b000; cfg_sa1 = 3'b111;
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
            check("stall_valid", out_valid, 1'b1);
            check("stall_d", out_d, 1'b0);
            check("stall_bout", out_bout, 1'b0);
            check("stall_mm", out_mismatch, 1'b0);
        end
        cfg_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_stall_d", out_d, 1'b1);
        check("post_stall_bout", out_bout, 1'b1);
        check("post_stall_mm", out_mismatch, 1'b1);
        check("post_stall_fault_active", fault_active, 1'b1);
        check("post_stall_vec_count", vec_count, 8'd14);

        // Mask write and accept in the same cycle: vector sees old masks
        cfg_we = 1'b1; cfg_sa0 = 3'b000; cfg_sa1 = 3'b000;
        @(posedge clk); #1;
        check("clear_fault_active", fault_active, 1'b0);
        cfg_sa0 = 3'b111; in_valid = 1'b1; in_vec = 3'b111;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("coll_d", out_d, 1'b1);
        check("coll_bout", out_bout, 1'b1);
        check("coll_mm", out_mismatch, 1'b0);
        check("coll_fault_active", fault_active, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("coll_next_d", out_d, 1'b0);
        check("coll_next_bout", out_bout, 1'b0);
        check("coll_next_mm", out_mismatch, 1'b1);

        // Random run against the model, starting from a fresh reset
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_vec_count", vec_count, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_sa0 = '0; m_sa1 = '0; m_vcnt = 0; m_ecnt = 0; held_v = 0;
        held_d = 0; held_b = 0; held_m = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_sa0   = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            cfg_sa1   = 3'($urandom_range(0, 7));
            #1;
            m_rdy = !held_v || out_ready;
            check("rnd_in_ready", in_ready, m_rdy);
            acc = in_valid && m_rdy;
            if (acc) begin
                f = ref_eval(ref_eff(in_vec, m_sa0, m_sa1));
                g = ref_eval(in_vec);
                held_v = 1'b1; held_d = f[1]; held_b = f[0]; held_m = (f != g);
                if (m_vcnt < 255) m_vcnt++;
                if (held_m && m_ecnt < 255) m_ecnt++;
            end else if (out_ready) begin
                held_v = 1'b0;
            end
            if (cfg_we) begin
                m_sa0 = cfg_sa0; m_sa1 = cfg_sa1;
            end
            @(posedge clk); #1;
            check("rnd_valid", out_valid, held_v);
            if (held_v) begin
                check("rnd_d", out_d, held_d);
                check("rnd_bout", out_bout, held_b);
                check("rnd_mm", out_mismatch, held_m);
            end
            check("rnd_fault_active", fault_active, |(m_sa0 | m_sa1));
            check("rnd_vec_count", vec_count, m_vcnt[7:0]);
            check("rnd_err_count", err_count, m_ecnt[7:0]);
        end
        in_valid = 1'b0; cfg_we = 1'b0;

        // Narrow counters: SA1 on Bin with vector 000 mismatches every time
        cfg_we2 = 1'b1; cfg_sa0_2 = 3'b000; cfg_sa1_2 = 3'b001; out_ready2 = 1'b1;
        @(posedge clk); #1;
        cfg_we2 = 1'b0; in_valid2 = 1'b1; in_vec2 = 3'b000;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            check("sat_vec_count", vec_count2, (i > 3) ? 2'd3 : 2'(i));
            check("sat_err_count", err_count2, (i > 3) ? 2'd3 : 2'(i));
        end
        check("sat_d", out_d2, 1'b1);
        check("sat_bout", out_bout2, 1'b1);
        check("sat_mm", out_mismatch2, 1'b1);
        in_valid2 = 1'b0; out_ready2 = 1'b0;
        @(posedge clk); #1;
        check("sat_hold_valid", out_valid2, 1'b1);
        check("sat_hold_vec_count", vec_count2, 2'd3);
        #2;
        rst_n2 = 1'b0;
        #1;
        check("mid_rst_valid", out_valid2, 1'b0);
        check("mid_rst_vec_count", vec_count2, 2'd0);
        check("mid_rst_err_count", err_count2, 2'd0);
        check("mid_rst_fault_active", fault_active2, 1'b0);
        @(posedge clk); #1;
        rst_n2 = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
